// File: rtl/rob_commit_ctrl_if.sv
// Signal bundle between the ROB commit controller and its neighbours:
// dispatch, the temporary register file, the architectural file and the store unit.
interface rob_commit_ctrl_if #(
   parameter int AW = 5,
   parameter int DW = 73
);
   // dispatch / allocation
   logic          alloc_req;
   logic [4:0]    alloc_rd;
   logic [31:0]   alloc_pc;
   logic [1:0]    alloc_type;
   logic          alloc_gnt;
   logic [AW-1:0] alloc_tag;
   logic          full;
   logic          empty;

   // temporary register file
   logic [DW-1:0] rf_data_in;
   logic [AW-1:0] rf_waddr;
   logic          rf_new_entry;
   logic [AW-1:0] rf_rd_addr;
   logic [DW-1:0] rf_data_out;
   logic          rf_flush;

   // retire side
   logic          commit_we;
   logic [4:0]    commit_addr;
   logic [31:0]   commit_data;
   logic          store_commit;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;

   modport slave (
      input  alloc_req, alloc_rd, alloc_pc, alloc_type, rf_data_out,
      output alloc_gnt, alloc_tag, full, empty,
      output rf_data_in, rf_waddr, rf_new_entry, rf_rd_addr, rf_flush,
      output commit_we, commit_addr, commit_data, store_commit,
      output redirect_valid, redirect_pc
   );

   modport master (
      output alloc_req, alloc_rd, alloc_pc, alloc_type, rf_data_out,
      input  alloc_gnt, alloc_tag, full, empty,
      input  rf_data_in, rf_waddr, rf_new_entry, rf_rd_addr, rf_flush,
      input  commit_we, commit_addr, commit_data, store_commit,
      input  redirect_valid, redirect_pc
   );
endinterface

// File: rtl/rob_commit_ctrl.sv
// Head/tail controller for the 32-entry speculative register file: allocates
// entries at the tail, retires completed entries in order from the head.
module rob_commit_ctrl #(
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH),
   parameter int DW    = 73
) (
   input  logic             clock,
   input  logic             reset,
   rob_commit_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      T_ALU    = 2'b00,
      T_LOAD   = 2'b01,
      T_STORE  = 2'b10,
      T_BRANCH = 2'b11
   } inst_type_e;

   typedef struct packed {
      logic [4:0]  rd_reg;
      logic [31:0] pc;
      inst_type_e  inst_type;
      logic [31:0] spec_data;
      logic        spec_valid;
      logic        valid;
   } entry_t;

   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW:0]   count;

   logic   full;
   logic   empty;
   logic   ready;
   logic   is_reg_write;
   logic   flush_hit;
   logic   grant;
   entry_t head_ent;
   entry_t new_ent;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

   assign head_ent     = entry_t'(bus.rf_data_out);
   assign ready        = ~empty & head_ent.valid & head_ent.spec_valid;
   assign is_reg_write = (head_ent.inst_type == T_ALU) || (head_ent.inst_type == T_LOAD);

   // A resolved branch whose next PC is not the fall-through squashes everything younger.
   assign flush_hit = ready & (head_ent.inst_type == T_BRANCH) &
                      (head_ent.spec_data != head_ent.pc + 32'd4);

   // Grant looks at this cycle's count only; a same-cycle retire does not free a slot early.
   assign grant = bus.alloc_req & ~full & ~bus.rf_flush & ~flush_hit;

   always_comb begin
      // NOTE: default every field first so no path through this block can infer a latch.
      new_ent            = '0;
      new_ent.rd_reg     = bus.alloc_rd;
      new_ent.pc         = bus.alloc_pc;
      new_ent.inst_type  = inst_type_e'(bus.alloc_type);
      new_ent.spec_valid = 1'b0;
      new_ent.valid      = 1'b1;
   end

   assign bus.alloc_gnt    = grant;
   assign bus.alloc_tag    = tail;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.rf_data_in   = DW'(new_ent);
   assign bus.rf_waddr     = tail;
   assign bus.rf_new_entry = grant;
   assign bus.rf_rd_addr   = head;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin : ptr_state
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush_hit) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (ready) head <= head + AW'(1);
         if (grant) tail <= tail + AW'(1);
         case ({grant, ready})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Retire results are registered: they appear the cycle after the head was seen ready.
   always_ff @(posedge clock or posedge reset) begin : retire_out
      if (reset) begin
         bus.commit_we      <= 1'b0;
         bus.commit_addr    <= '0;
         bus.commit_data    <= '0;
         bus.store_commit   <= 1'b0;
         bus.rf_flush       <= 1'b0;
         bus.redirect_valid <= 1'b0;
         bus.redirect_pc    <= '0;
      end else begin
         bus.commit_we      <= ready & is_reg_write & (head_ent.rd_reg != 5'd0);
         bus.store_commit   <= ready & (head_ent.inst_type == T_STORE);
         bus.rf_flush       <= flush_hit;
         bus.redirect_valid <= flush_hit;
         if (ready & is_reg_write) begin
            bus.commit_addr <= head_ent.rd_reg;
            bus.commit_data <= head_ent.spec_data;
         end
         if (flush_hit) bus.redirect_pc <= head_ent.spec_data;
      end
   end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: a behavioural temporary file plus a
// program-order queue model predicts grants, tags, commits, stores and flushes.
module tb_rob_commit_ctrl;
   localparam int DEPTH = 32;
   localparam int AW    = 5;
   localparam int DW    = 73;

   logic clock;
   logic reset;

   rob_commit_ctrl_if #(.AW(AW), .DW(DW)) bus ();

   rob_commit_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural temporary register file with an execution-unit completion port.
   logic [DW-1:0] rf_file [DEPTH];
   logic          comp_en;
   logic [AW-1:0] comp_tag;
   logic [31:0]   comp_data;

   assign bus.rf_data_out = rf_file[bus.rf_rd_addr];

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) rf_file[i] <= '0;
      end else if (bus.rf_flush) begin
         for (int i = 0; i < DEPTH; i++) rf_file[i] <= '0;
      end else begin
         if (comp_en) begin
            rf_file[comp_tag][33:2] <= comp_data;
            rf_file[comp_tag][1]    <= 1'b1;
         end
         if (bus.rf_new_entry) rf_file[bus.rf_waddr] <= bus.rf_data_in;
      end
   end

   // Reference model: in-flight instructions in program order.
   typedef struct {
      logic [4:0]  tag;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [1:0]  typ;
      logic [31:0] data;
      bit          done;
   } rob_ent_t;

   rob_ent_t    q[$];
   logic [4:0]  m_head, m_tail;
   bit          m_flush;
   bit          e_we, e_store, e_flush;
   logic [4:0]  e_addr;
   logic [31:0] e_data, e_rpc;
   bit          last_gnt;
   logic [4:0]  last_tag;
   int          n_checks, n_pass;

   task automatic model_reset();
      q.delete();
      m_head  = '0;
      m_tail  = '0;
      m_flush = 1'b0;
      e_we    = 1'b0;
      e_store = 1'b0;
      e_flush = 1'b0;
      e_addr  = '0;
      e_data  = '0;
      e_rpc   = '0;
   endtask

   // One clock cycle: drive at negedge, compare, predict, advance past posedge.
   task automatic step(input bit req, input logic [4:0] rd, input logic [31:0] pc,
                       input logic [1:0] typ, input bit cen, input logic [4:0] ctag,
                       input logic [31:0] cdata);
      int            cnt;
      bit            rdy, mis, gnt;
      rob_ent_t      h;
      logic [DW-1:0] exp_in;
      @(negedge clock);
      bus.alloc_req  = req;
      bus.alloc_rd   = rd;
      bus.alloc_pc   = pc;
      bus.alloc_type = typ;
      comp_en        = cen;
      comp_tag       = ctag;
      comp_data      = cdata;
      #1;
      cnt = q.size();
      rdy = (cnt > 0) && q[0].done;
      h   = '{default: '0};
      if (rdy) h = q[0];
      mis = rdy && (h.typ == 2'b11) && (h.data != h.pc + 32'd4);
      gnt = req && (cnt < DEPTH) && !m_flush && !mis;
      exp_in = {rd, pc, typ, 32'd0, 1'b0, 1'b1};
      last_gnt = bus.alloc_gnt;
      last_tag = bus.alloc_tag;

      n_checks++;
      if (bus.alloc_gnt !== gnt) $display("FAIL alloc_gnt t=%0t got %b want %b", $time, bus.alloc_gnt, gnt);
      else n_pass++;
      n_checks++;
      if (bus.rf_new_entry !== gnt) $display("FAIL rf_new_entry t=%0t got %b want %b", $time, bus.rf_new_entry, gnt);
      else n_pass++;
      n_checks++;
      if (bus.full !== (cnt == DEPTH)) $display("FAIL full t=%0t got %b want %b", $time, bus.full, cnt == DEPTH);
      else n_pass++;
      n_checks++;
      if (bus.empty !== (cnt == 0)) $display("FAIL empty t=%0t got %b want %b", $time, bus.empty, cnt == 0);
      else n_pass++;
      n_checks++;
      if (bus.rf_rd_addr !== m_head) $display("FAIL rf_rd_addr t=%0t got %0d want %0d", $time, bus.rf_rd_addr, m_head);
      else n_pass++;
      n_checks++;
      if (bus.rf_waddr !== m_tail) $display("FAIL rf_waddr t=%0t got %0d want %0d", $time, bus.rf_waddr, m_tail);
      else n_pass++;
      if (gnt) begin
         n_checks++;
         if (bus.alloc_tag !== m_tail) $display("FAIL alloc_tag t=%0t got %0d want %0d", $time, bus.alloc_tag, m_tail);
         else n_pass++;
         n_checks++;
         if (bus.rf_data_in !== exp_in) $display("FAIL rf_data_in t=%0t got %h want %h", $time, bus.rf_data_in, exp_in);
         else n_pass++;
      end
      n_checks++;
      if (bus.commit_we !== e_we) $display("FAIL commit_we t=%0t got %b want %b", $time, bus.commit_we, e_we);
      else n_pass++;
      if (e_we) begin
         n_checks++;
         if (bus.commit_addr !== e_addr || bus.commit_data !== e_data)
            $display("FAIL commit_wr t=%0t got r%0d=%h want r%0d=%h", $time, bus.commit_addr, bus.commit_data, e_addr, e_data);
         else n_pass++;
      end
      n_checks++;
      if (bus.store_commit !== e_store) $display("FAIL store_commit t=%0t got %b want %b", $time, bus.store_commit, e_store);
      else n_pass++;
      n_checks++;
      if (bus.rf_flush !== e_flush || bus.redirect_valid !== e_flush)
         $display("FAIL flush t=%0t got rf_flush=%b redirect_valid=%b want %b", $time, bus.rf_flush, bus.redirect_valid, e_flush);
      else n_pass++;
      if (e_flush) begin
         n_checks++;
         if (bus.redirect_pc !== e_rpc) $display("FAIL redirect_pc t=%0t got %h want %h", $time, bus.redirect_pc, e_rpc);
         else n_pass++;
      end

      e_we    = rdy && (h.typ == 2'b00 || h.typ == 2'b01) && (h.rd != 5'd0);
      e_addr  = h.rd;
      e_data  = h.data;
      e_store = rdy && (h.typ == 2'b10);
      e_flush = mis;
      e_rpc   = h.data;

      if (mis) begin
         q.delete();
         m_head = '0;
         m_tail = '0;
      end else begin
         if (cen) begin
            foreach (q[i]) if (q[i].tag == ctag) begin
               q[i].done = 1'b1;
               q[i].data = cdata;
            end
         end
         if (rdy) begin
            void'(q.pop_front());
            m_head = m_head + 5'd1;
         end
         if (gnt) begin
            q.push_back('{tag: m_tail, rd: rd, pc: pc, typ: typ, data: 32'd0, done: 1'b0});
            m_tail = m_tail + 5'd1;
         end
      end
      m_flush = mis;
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 32'd0, 2'b00, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic alloc_one(input logic [4:0] rd, input logic [31:0] pc, input logic [1:0] typ);
      step(1'b1, rd, pc, typ, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic complete(input logic [4:0] tag, input logic [31:0] data);
      step(1'b0, 5'd0, 32'd0, 2'b00, 1'b1, tag, data);
   endtask

   // Completes the oldest unfinished entry each cycle (branches predicted correctly).
   task automatic drain(input int budget);
      int n = 0;
      while ((q.size() != 0 || e_we || e_store || e_flush) && n < budget) begin
         int idx = -1;
         foreach (q[i]) if (idx < 0 && !q[i].done) idx = i;
         if (idx >= 0)
            complete(q[idx].tag, (q[idx].typ == 2'b11) ? q[idx].pc + 32'd4 : $urandom);
         else
            idle();
         n++;
      end
      n_checks++;
      if (q.size() != 0) $display("FAIL drain_timeout got %0d entries left want 0", q.size());
      else n_pass++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      #1;
      n_checks++;
      if (bus.commit_we !== 1'b0 || bus.store_commit !== 1'b0 || bus.rf_flush !== 1'b0 ||
          bus.redirect_valid !== 1'b0 || bus.commit_addr !== 5'd0 || bus.commit_data !== 32'd0 ||
          bus.redirect_pc !== 32'd0)
         $display("FAIL reset_regs got we=%b st=%b fl=%b rv=%b want all 0",
                  bus.commit_we, bus.store_commit, bus.rf_flush, bus.redirect_valid);
      else n_pass++;
      n_checks++;
      if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.rf_rd_addr !== 5'd0 || bus.rf_waddr !== 5'd0)
         $display("FAIL reset_ptrs got empty=%b full=%b head=%0d tail=%0d want 1 0 0 0",
                  bus.empty, bus.full, bus.rf_rd_addr, bus.rf_waddr);
      else n_pass++;
      @(negedge clock);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_alloc_basic();
      logic [4:0] diff;
      for (int i = 0; i < 3; i++) begin
         alloc_one(5'(i + 1), 32'h1000 + 32'(4 * i), 2'b00);
         n_checks++;
         if (last_gnt !== 1'b1 || last_tag !== 5'(i))
            $display("FAIL alloc_basic_tag got gnt=%b tag=%0d want 1 %0d", last_gnt, last_tag, i);
         else n_pass++;
      end
      diff = bus.rf_waddr - bus.rf_rd_addr;
      n_checks++;
      if (diff !== 5'd3 || bus.empty !== 1'b0) $display("FAIL alloc_basic_count got %0d empty=%b want 3 0", diff, bus.empty);
      else n_pass++;
   endtask

   task automatic test_in_order();
      complete(5'd1, 32'h0000_00AA);
      idle();
      n_checks++;
      if (bus.commit_we !== 1'b0) $display("FAIL in_order_hold got commit_we=%b want 0", bus.commit_we);
      else n_pass++;
      complete(5'd0, 32'h0000_0055);
      idle();
      n_checks++;
      if (bus.commit_we !== 1'b1 || bus.commit_addr !== 5'd1 || bus.commit_data !== 32'h55)
         $display("FAIL in_order_first got we=%b r%0d=%h want 1 r1=55", bus.commit_we, bus.commit_addr, bus.commit_data);
      else n_pass++;
      idle();
      n_checks++;
      if (bus.commit_we !== 1'b1 || bus.commit_addr !== 5'd2 || bus.commit_data !== 32'hAA)
         $display("FAIL in_order_second got we=%b r%0d=%h want 1 r2=aa", bus.commit_we, bus.commit_addr, bus.commit_data);
      else n_pass++;
   endtask

   task automatic test_full();
      int start;
      drain(20);
      start = int'(m_tail);
      for (int i = 0; i < DEPTH; i++) begin
         alloc_one(5'($urandom_range(1, 31)), 32'h2000 + 32'(4 * i), 2'b00);
         if (((start + i + 1) % DEPTH) == 0) begin
            n_checks++;
            if (bus.rf_waddr !== 5'd0) $display("FAIL tail_wrap got %0d want 0", bus.rf_waddr);
            else n_pass++;
         end
      end
      n_checks++;
      if (bus.full !== 1'b1 || bus.empty !== 1'b0) $display("FAIL full_flag got full=%b empty=%b want 1 0", bus.full, bus.empty);
      else n_pass++;
      alloc_one(5'd9, 32'h3000, 2'b00);
      n_checks++;
      if (last_gnt !== 1'b0) $display("FAIL alloc_33 got gnt=%b want 0", last_gnt);
      else n_pass++;
      step(1'b1, 5'd9, 32'h3000, 2'b00, 1'b1, q[0].tag, 32'h1234_5678);
      alloc_one(5'd9, 32'h3000, 2'b00);
      n_checks++;
      if (last_gnt !== 1'b0) $display("FAIL full_no_bypass got gnt=%b want 0", last_gnt);
      else n_pass++;
      alloc_one(5'd9, 32'h3000, 2'b00);
      n_checks++;
      if (last_gnt !== 1'b1) $display("FAIL full_after_retire got gnt=%b want 1", last_gnt);
      else n_pass++;
      drain(120);
   endtask

   task automatic test_store_rd0();
      int         st_cnt = 0;
      int         we_cnt = 0;
      logic [4:0] start  = m_head;
      alloc_one(5'd7, 32'h40, 2'b10);
      alloc_one(5'd0, 32'h44, 2'b00);
      complete(q[0].tag, 32'hDEAD_BEEF);
      st_cnt += int'(bus.store_commit);
      we_cnt += int'(bus.commit_we);
      complete(q[1].tag, 32'h0BAD_F00D);
      st_cnt += int'(bus.store_commit);
      we_cnt += int'(bus.commit_we);
      for (int i = 0; i < 4; i++) begin
         idle();
         st_cnt += int'(bus.store_commit);
         we_cnt += int'(bus.commit_we);
      end
      n_checks++;
      if (st_cnt != 1 || we_cnt != 0) $display("FAIL store_rd0_pulses got store=%0d we=%0d want 1 0", st_cnt, we_cnt);
      else n_pass++;
      n_checks++;
      if (bus.rf_rd_addr !== start + 5'd2) $display("FAIL store_rd0_head got %0d want %0d", bus.rf_rd_addr, start + 5'd2);
      else n_pass++;
   endtask

   task automatic test_branch();
      alloc_one(5'd0, 32'h100, 2'b11);
      complete(q[0].tag, 32'h104);
      idle();
      n_checks++;
      if (bus.rf_flush !== 1'b0 || bus.redirect_valid !== 1'b0)
         $display("FAIL branch_taken_ok got rf_flush=%b redirect=%b want 0 0", bus.rf_flush, bus.redirect_valid);
      else n_pass++;
      alloc_one(5'd0, 32'h180, 2'b11);
      alloc_one(5'd4, 32'h184, 2'b00);
      alloc_one(5'd5, 32'h188, 2'b01);
      complete(q[0].tag, 32'h200);
      alloc_one(5'd6, 32'h18C, 2'b00);
      n_checks++;
      if (last_gnt !== 1'b0) $display("FAIL branch_ready_block got gnt=%b want 0", last_gnt);
      else n_pass++;
      n_checks++;
      if (bus.rf_flush !== 1'b1 || bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h200)
         $display("FAIL mispredict got rf_flush=%b rv=%b pc=%h want 1 1 200", bus.rf_flush, bus.redirect_valid, bus.redirect_pc);
      else n_pass++;
      n_checks++;
      if (bus.empty !== 1'b1 || bus.rf_rd_addr !== 5'd0 || bus.rf_waddr !== 5'd0)
         $display("FAIL mispredict_clear got empty=%b head=%0d tail=%0d want 1 0 0", bus.empty, bus.rf_rd_addr, bus.rf_waddr);
      else n_pass++;
      alloc_one(5'd6, 32'h200, 2'b00);
      n_checks++;
      if (last_gnt !== 1'b0) $display("FAIL flush_cycle_block got gnt=%b want 0", last_gnt);
      else n_pass++;
      n_checks++;
      if (bus.rf_flush !== 1'b0 || bus.redirect_valid !== 1'b0)
         $display("FAIL flush_one_cycle got rf_flush=%b rv=%b want 0 0", bus.rf_flush, bus.redirect_valid);
      else n_pass++;
      alloc_one(5'd6, 32'h200, 2'b00);
      n_checks++;
      if (last_gnt !== 1'b1 || last_tag !== 5'd0) $display("FAIL after_flush_alloc got gnt=%b tag=%0d want 1 0", last_gnt, last_tag);
      else n_pass++;
      drain(20);
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         bit          req, cen;
         logic [4:0]  rd, ctag;
         logic [31:0] pc, cdata;
         logic [1:0]  typ;
         req   = ($urandom_range(0, 9) < 6);
         rd    = 5'($urandom_range(0, 31));
         pc    = $urandom & 32'hFFFF_FFFC;
         typ   = 2'($urandom_range(0, 3));
         cen   = 1'b0;
         ctag  = '0;
         cdata = '0;
         if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
            int idx = $urandom_range(0, q.size() - 1);
            if (!q[idx].done) begin
               cen  = 1'b1;
               ctag = q[idx].tag;
               if (q[idx].typ == 2'b11)
                  cdata = ($urandom_range(0, 3) != 0) ? q[idx].pc + 32'd4 : ($urandom & 32'hFFFF_FFFC);
               else
                  cdata = $urandom;
            end
         end
         step(req, rd, pc, typ, cen, ctag, cdata);
      end
      drain(120);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 6; i++) alloc_one(5'(10 + i), 32'h4000 + 32'(4 * i), 2'b00);
      complete(q[0].tag, 32'hCAFE_0001);
      idle();
      n_checks++;
      if (bus.commit_we !== 1'b1 || bus.commit_addr !== 5'd10)
         $display("FAIL reset_mid_inflight got we=%b r%0d want 1 r10", bus.commit_we, bus.commit_addr);
      else n_pass++;
      comp_en       = 1'b0;
      bus.alloc_req = 1'b0;
      reset         = 1'b1;
      #1;
      n_checks++;
      if (bus.commit_we !== 1'b0 || bus.commit_addr !== 5'd0 || bus.commit_data !== 32'd0 ||
          bus.store_commit !== 1'b0 || bus.rf_flush !== 1'b0 || bus.redirect_valid !== 1'b0)
         $display("FAIL reset_mid_regs got we=%b r%0d=%h want all 0", bus.commit_we, bus.commit_addr, bus.commit_data);
      else n_pass++;
      n_checks++;
      if (bus.rf_rd_addr !== 5'd0 || bus.rf_waddr !== 5'd0 || bus.empty !== 1'b1)
         $display("FAIL reset_mid_ptrs got head=%0d tail=%0d empty=%b want 0 0 1", bus.rf_rd_addr, bus.rf_waddr, bus.empty);
      else n_pass++;
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      alloc_one(5'd3, 32'h5000, 2'b00);
      n_checks++;
      if (last_gnt !== 1'b1 || last_tag !== 5'd0) $display("FAIL reset_mid_realloc got gnt=%b tag=%0d want 1 0", last_gnt, last_tag);
      else n_pass++;
      drain(20);
   endtask

   initial begin
      n_checks       = 0;
      n_pass         = 0;
      reset          = 1'b0;
      bus.alloc_req  = 1'b0;
      bus.alloc_rd   = '0;
      bus.alloc_pc   = '0;
      bus.alloc_type = '0;
      comp_en        = 1'b0;
      comp_tag       = '0;
      comp_data      = '0;
      model_reset();
      #2;
      test_reset();
      test_alloc_basic();
      test_in_order();
      test_full();
      test_store_rd0();
      test_branch();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
